// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch stage feeding the instruction register.
//
// Holds the fetch PC and issues one outstanding word read at a time. Returned
// words go into a small prefetch FIFO of {pc, ins} entries. The head entry is
// shown on ins_out/pc_out, and il_out strobes it into the IR. A redirect
// (pc_load_in) flushes the FIFO and discards any read still in flight.
//
// Optional build macro IFETCH_BYPASS_EN: when the FIFO is empty and the
// consumer is waiting, a returning word goes straight to the IR in its ack
// cycle instead of being pushed first.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   fetch_en_in         permits issuing new memory reads
//   pc_load_in          redirect strobe, with pc_target_in
//   imem_req_out        read request, held with imem_addr_out until ack
//   imem_ack_in         read complete, imem_data_in valid this cycle
//   ins_req_in          consumer wants the next instruction
//   ins_out, pc_out     head instruction and its PC
//   il_out              instruction load strobe
//   empty_out, full_out FIFO status
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | no read outstanding
// WAIT  | read outstanding, returned word is kept
// DROP  | read outstanding after a redirect, word discarded

module ifetch_unit #(
    parameter logic [15:0] PC_RESET   = 16'h0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en_in,
    input  logic        pc_load_in,
    input  logic [15:0] pc_target_in,
    output logic        imem_req_out,
    output logic [15:0] imem_addr_out,
    input  logic        imem_ack_in,
    input  logic [15:0] imem_data_in,
    input  logic        ins_req_in,
    output logic [15:0] ins_out,
    output logic        il_out,
    output logic [15:0] pc_out,
    output logic        empty_out,
    output logic        full_out
);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;

    localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

    state_t      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [15:0] drop_addr_q, drop_addr_d;
    logic [1:0]  rd_ptr_q, wr_ptr_q;
    logic [2:0]  count_q;
    logic [15:0] last_ins_q, last_pc_q;
    logic [15:0] fifo_ins_q [4];
    logic [15:0] fifo_pc_q  [4];

    logic       empty, full, bypass_hit, pop, push, issue_ok;
    logic [2:0] count_after_pop, count_after_push;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    assign empty = (count_q == 3'd0);
    assign full  = (count_q == DEPTH_C);

`ifdef IFETCH_BYPASS_EN
    assign bypass_hit = empty && (state_q == WAIT) && imem_ack_in
                        && ins_req_in && !pc_load_in;
`else
    assign bypass_hit = 1'b0;
`endif

    assign il_out = ins_req_in && !pc_load_in && (!empty || bypass_hit);
    assign pop    = il_out && !empty;
    // A bypassed word is consumed directly and never occupies a slot.
    assign push   = (state_q == WAIT) && imem_ack_in && !pc_load_in && !bypass_hit;

    assign count_after_pop  = count_q - 3'(pop);
    assign count_after_push = count_after_pop + 3'(push);
    // A new read is only allowed if its word is guaranteed a free slot.
    assign issue_ok = fetch_en_in && (count_after_push < DEPTH_C);

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        case (state_q)
            IDLE: begin
                if (pc_load_in) begin
                    fetch_pc_d = pc_target_in;
                end else if (issue_ok) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (pc_load_in) begin
                    fetch_pc_d  = pc_target_in;
                    drop_addr_d = fetch_pc_q;
                    state_d     = imem_ack_in ? IDLE : DROP;
                end else if (imem_ack_in) begin
                    fetch_pc_d = fetch_pc_q + 16'd1;
                    state_d    = issue_ok ? WAIT : IDLE;
                end
            end
            DROP: begin
                if (pc_load_in) begin
                    fetch_pc_d = pc_target_in;
                end
                if (imem_ack_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= PC_RESET;
            drop_addr_q <= PC_RESET;
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            last_ins_q  <= 16'h0000;
            last_pc_q   <= PC_RESET;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
            if (pc_load_in) begin
                rd_ptr_q <= 2'd0;
                wr_ptr_q <= 2'd0;
                count_q  <= 3'd0;
            end else begin
                if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
                if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
                count_q <= count_after_push;
            end
            if (il_out) begin
                last_ins_q <= ins_out;
                last_pc_q  <= pc_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ins_q[wr_ptr_q] <= imem_data_in;
            fifo_pc_q[wr_ptr_q]  <= fetch_pc_q;
        end
    end

    always_comb begin
        ins_out = last_ins_q;
        pc_out  = last_pc_q;
        if (!empty) begin
            ins_out = fifo_ins_q[rd_ptr_q];
            pc_out  = fifo_pc_q[rd_ptr_q];
        end else if (bypass_hit) begin
            ins_out = imem_data_in;
            pc_out  = fetch_pc_q;
        end
    end

    assign imem_req_out  = (state_q != IDLE);
    // In DROP the memory still owns the old request, so its address stays put.
    assign imem_addr_out = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
    assign empty_out     = empty;
    assign full_out      = full;

    assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst, fetch_en, pc_load, imem_ack, ins_req;
    logic [15:0] pc_target, imem_data;
    logic        imem_req, il, empty, full;
    logic [15:0] imem_addr, ins, pc;

    logic        w_rst, w_fetch_en, w_pc_load, w_ack, w_ins_req;
    logic [15:0] w_target, w_data;
    logic        w_req, w_il, w_empty, w_full;
    logic [15:0] w_addr, w_ins, w_pc;

    int checks = 0;
    int errors = 0;
    int mem_delay = 1;
    int mem_cnt = 0;

    always #5 clk = ~clk;

    ifetch_unit dut (
        .clk(clk), .rst(rst), .fetch_en_in(fetch_en), .pc_load_in(pc_load),
        .pc_target_in(pc_target), .imem_req_out(imem_req), .imem_addr_out(imem_addr),
        .imem_ack_in(imem_ack), .imem_data_in(imem_data), .ins_req_in(ins_req),
        .ins_out(ins), .il_out(il), .pc_out(pc), .empty_out(empty), .full_out(full)
    );

    ifetch_unit #(.PC_RESET(16'hFFFF), .FIFO_DEPTH(2)) dut_w (
        .clk(clk), .rst(w_rst), .fetch_en_in(w_fetch_en), .pc_load_in(w_pc_load),
        .pc_target_in(w_target), .imem_req_out(w_req), .imem_addr_out(w_addr),
        .imem_ack_in(w_ack), .imem_data_in(w_data), .ins_req_in(w_ins_req),
        .ins_out(w_ins), .il_out(w_il), .pc_out(w_pc), .empty_out(w_empty), .full_out(w_full)
    );

    // Memory model: acks once the request has been up mem_delay cycles,
    // then every further cycle the request stays up; data = addr + 1000.
    initial begin
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (imem_req === 1'b1) begin
                imem_ack  = (mem_cnt >= mem_delay);
                imem_data = imem_addr + 16'h1000;
                mem_cnt++;
            end else begin
                imem_ack = 1'b0;
                mem_cnt  = 0;
            end
        end
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        pc_load = 1'b0;
        pc_target = 16'h0000;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        fetch_en = 1'b1; ins_req = 1'b0; pc_load = 1'b0; pc_target = 16'h0000;
        rst = 1'b1;
        cyc();
        cyc();
        smp();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0h expected 0", imem_req); end
        checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %04h expected 0000", imem_addr); end
        checks++; if (il !== 1'b0) begin errors++; $display("FAIL reset_il: got %0h expected 0", il); end
        checks++; if (ins !== 16'h0000) begin errors++; $display("FAIL reset_ins: got %04h expected 0000", ins); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %04h expected 0000", pc); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0h expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0h expected 0", full); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_streaming;
        int n;
        int idx [3];
        logic [15:0] gi [3];
        logic [15:0] gp [3];
        int exp_first;
`ifdef IFETCH_BYPASS_EN
        exp_first = 2;
`else
        exp_first = 3;
`endif
        n = 0;
        for (int k = 0; k < 3; k++) begin idx[k] = -1; gi[k] = 16'hxxxx; gp[k] = 16'hxxxx; end
        fetch_en = 1'b1; ins_req = 1'b1; mem_delay = 1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            smp();
            if (i == 1) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL stream_first_req: got req=%0h addr=%04h expected req=1 addr=0000", imem_req, imem_addr); end
            end
            if (il === 1'b1 && n < 3) begin idx[n] = i; gi[n] = ins; gp[n] = pc; n++; end
            cyc();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL stream_count: got %0d strobes expected 3 within budget", n); end
        checks++; if (idx[0] != exp_first) begin errors++; $display("FAIL stream_latency: got cycle %0d expected %0d", idx[0], exp_first); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (gi[k] !== 16'h1000 + 16'(k) || gp[k] !== 16'(k)) begin errors++; $display("FAIL stream_word%0d: got ins=%04h pc=%04h expected ins=%04h pc=%04h", k, gi[k], gp[k], 16'h1000 + 16'(k), 16'(k)); end
        end
        checks++; if (idx[1] != idx[0] + 1 || idx[2] != idx[1] + 1) begin errors++; $display("FAIL stream_gaps: got cycles %0d,%0d,%0d expected consecutive", idx[0], idx[1], idx[2]); end
    endtask

    task automatic test_backpressure;
        fetch_en = 1'b1; ins_req = 1'b0; mem_delay = 1;
        do_reset();
        for (int i = 0; i < 4; i++) cyc();
        smp();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL bp_full: got %0h expected 1", full); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_req: got %0h expected 0", imem_req); end
        checks++; if (imem_addr !== 16'h0002) begin errors++; $display("FAIL bp_addr: got %04h expected 0002", imem_addr); end
        checks++; if (il !== 1'b0) begin errors++; $display("FAIL bp_il_idle: got %0h expected 0", il); end
        cyc();
        ins_req = 1'b1;
        smp();
        checks++; if (il !== 1'b1 || ins !== 16'h1000 || pc !== 16'h0000) begin errors++; $display("FAIL bp_pop: got il=%0h ins=%04h pc=%04h expected il=1 ins=1000 pc=0000", il, ins, pc); end
        cyc();
        ins_req = 1'b0;
        smp();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin errors++; $display("FAIL bp_reissue: got req=%0h addr=%04h expected req=1 addr=0002", imem_req, imem_addr); end
        checks++; if (full !== 1'b0 || ins !== 16'h1001) begin errors++; $display("FAIL bp_after_pop: got full=%0h ins=%04h expected full=0 ins=1001", full, ins); end
    endtask

    task automatic test_redirect_inflight;
        logic        found;
        logic [15:0] gi, gp;
        found = 1'b0; gi = 16'hxxxx; gp = 16'hxxxx;
        fetch_en = 1'b1; ins_req = 1'b1; mem_delay = 3;
        do_reset();
        cyc();
        cyc();
        pc_load = 1'b1; pc_target = 16'h0040;
        smp();
        checks++; if (il !== 1'b0) begin errors++; $display("FAIL redir_il: got %0h expected 0", il); end
        cyc();
        pc_load = 1'b0;
        smp();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || empty !== 1'b1) begin errors++; $display("FAIL redir_drop: got req=%0h addr=%04h empty=%0h expected req=1 addr=0000 empty=1", imem_req, imem_addr, empty); end
        for (int i = 0; i < 20; i++) begin
            cyc();
            smp();
            if (i == 1) begin
                checks++; if (imem_req !== 1'b0 || empty !== 1'b1) begin errors++; $display("FAIL redir_discard: got req=%0h empty=%0h expected req=0 empty=1", imem_req, empty); end
            end
            if (i == 2) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL redir_newaddr: got req=%0h addr=%04h expected req=1 addr=0040", imem_req, imem_addr); end
            end
            if (il === 1'b1 && !found) begin found = 1'b1; gi = ins; gp = pc; end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL redir_timeout: got no strobe expected one within budget"); end
        checks++; if (gi !== 16'h1040 || gp !== 16'h0040) begin errors++; $display("FAIL redir_first: got ins=%04h pc=%04h expected ins=1040 pc=0040", gi, gp); end
        mem_delay = 1;
    endtask

    task automatic test_redirect_consume;
        fetch_en = 1'b1; ins_req = 1'b0; mem_delay = 1;
        do_reset();
        for (int i = 0; i < 4; i++) cyc();
        smp();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL rc_full: got %0h expected 1", full); end
        cyc();
        ins_req = 1'b1; pc_load = 1'b1; pc_target = 16'h0080;
        smp();
        checks++; if (il !== 1'b0) begin errors++; $display("FAIL rc_il: got %0h expected 0", il); end
        cyc();
        ins_req = 1'b0; pc_load = 1'b0;
        smp();
        checks++; if (empty !== 1'b1 || full !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL rc_flush: got empty=%0h full=%0h req=%0h expected empty=1 full=0 req=0", empty, full, imem_req); end
        checks++; if (ins !== 16'h0000 || pc !== 16'h0000) begin errors++; $display("FAIL rc_hold: got ins=%04h pc=%04h expected ins=0000 pc=0000", ins, pc); end
        cyc();
        smp();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin errors++; $display("FAIL rc_newaddr: got req=%0h addr=%04h expected req=1 addr=0080", imem_req, imem_addr); end
    endtask

    task automatic test_wrap;
        w_rst = 1'b1; w_fetch_en = 1'b1; w_ins_req = 1'b1; w_pc_load = 1'b0;
        w_target = 16'h0000; w_ack = 1'b0; w_data = 16'h0000;
        cyc();
        cyc();
        w_rst = 1'b0;
        smp();
        checks++; if (w_req !== 1'b0 || w_addr !== 16'hFFFF || w_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_reset: got req=%0h addr=%04h pc=%04h expected req=0 addr=FFFF pc=FFFF", w_req, w_addr, w_pc); end
        cyc();
        smp();
        checks++; if (w_req !== 1'b1 || w_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_first: got req=%0h addr=%04h expected req=1 addr=FFFF", w_req, w_addr); end
        cyc();
        w_ack = 1'b1; w_data = 16'hABCD;
        smp();
`ifdef IFETCH_BYPASS_EN
        checks++; if (w_il !== 1'b1 || w_ins !== 16'hABCD || w_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_bypass: got il=%0h ins=%04h pc=%04h expected il=1 ins=ABCD pc=FFFF", w_il, w_ins, w_pc); end
`else
        checks++; if (w_il !== 1'b0) begin errors++; $display("FAIL wrap_nobypass: got il=%0h expected 0", w_il); end
`endif
        cyc();
        w_ack = 1'b0;
        smp();
        checks++; if (w_req !== 1'b1 || w_addr !== 16'h0000) begin errors++; $display("FAIL wrap_second: got req=%0h addr=%04h expected req=1 addr=0000", w_req, w_addr); end
`ifdef IFETCH_BYPASS_EN
        checks++; if (w_il !== 1'b0 || w_empty !== 1'b1) begin errors++; $display("FAIL wrap_after: got il=%0h empty=%0h expected il=0 empty=1", w_il, w_empty); end
`else
        checks++; if (w_il !== 1'b1 || w_ins !== 16'hABCD || w_pc !== 16'hFFFF) begin errors++; $display("FAIL wrap_pop: got il=%0h ins=%04h pc=%04h expected il=1 ins=ABCD pc=FFFF", w_il, w_ins, w_pc); end
`endif
    endtask

    initial begin
        w_rst = 1'b1; w_fetch_en = 1'b0; w_ins_req = 1'b0; w_pc_load = 1'b0;
        w_target = 16'h0000; w_ack = 1'b0; w_data = 16'h0000;
        test_reset();
        test_streaming();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_consume();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage directly upstream of the instruction register.
- Holds the fetch PC and issues single-outstanding word reads to instruction memory.
- Buffers returned words in a small prefetch FIFO. Presents the head word on ins_out with a one-cycle load strobe il_out, which drives the IR's il_in/ins_in.
- Handles control-flow redirects by flushing the buffer and discarding any in-flight read.

Parameters:
- PC_RESET, 16'h0000: fetch PC and pc_out value after reset.
- FIFO_DEPTH, 2: prefetch entries (legal 1..4). Each entry holds {pc[15:0], ins[15:0]}.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- fetch_en_in  in  1  permits issuing new memory reads
- pc_load_in  in  1  redirect strobe
- pc_target_in  in  16  redirect target PC
- imem_req_out  out  1  memory read request
- imem_addr_out  out  16  word address of the request
- imem_ack_in  in  1  read complete; imem_data_in valid this cycle
- imem_data_in  in  16  read data
- ins_req_in  in  1  consumer (control unit) requests the next instruction
- ins_out  out  16  head instruction, to IR ins_in
- il_out  out  1  instruction load strobe, to IR il_in
- pc_out  out  16  PC of the head instruction
- empty_out  out  1  FIFO empty
- full_out  out  1  FIFO count == FIFO_DEPTH

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, fetch PC=PC_RESET, FIFO count=0.
  - imem_req_out=0, imem_addr_out=PC_RESET.
  - il_out=0, ins_out=16'h0000, pc_out=PC_RESET.
  - empty_out=1, full_out=0.
  - Reset mid-request abandons the read; any ack in the following cycles is ignored while in IDLE.
- States: IDLE, WAIT (read outstanding, data kept), DROP (read outstanding, data discarded).
  - imem_req_out = (state != IDLE).
  - imem_addr_out = fetch PC, held stable while req=1.
- Issue condition: fetch_en_in && (count_after_pop + 1 <= FIFO_DEPTH), where count_after_pop accounts for a same-cycle pop.
- IDLE:
  - issue condition true and no pc_load_in -> WAIT.
  - pc_load_in -> fetch PC=pc_target_in, stay IDLE.
- WAIT:
  - ack and no pc_load_in:
    - push {fetch PC, imem_data_in}; fetch PC+1 (wraps FFFF->0000).
    - Then -> WAIT if the issue condition still holds after the push, else -> IDLE.
  - pc_load_in (with or without ack):
    - flush FIFO; fetch PC=pc_target_in; data is discarded.
    - With ack -> IDLE; without ack -> DROP.
- DROP:
  - req stays 1 with the old address; the memory is never withdrawn from.
  - on ack: discard data -> IDLE.
  - further pc_load_in: update fetch PC only, stay DROP.
- Pop:
  - il_out = ins_req_in && !empty && !pc_load_in (combinational).
  - At the edge, the head is removed.
  - ins_out/pc_out show the head entry combinationally; when empty they hold the last popped values (0/PC_RESET after reset).
- Simultaneous push and pop: count unchanged; order preserved.
- Push never occurs when full; this is guaranteed by the issue condition. An assertion checks it.
- Fetch latency (no bypass):
  - read issued cycle N, ack cycle N+1 at the earliest.
  - il_out at cycle N+2 at the earliest.

Optional Feature:
- Macro IFETCH_BYPASS_EN.
- When defined: if FIFO empty, state WAIT, imem_ack_in=1, ins_req_in=1 and no pc_load_in:
  - ins_out=imem_data_in, pc_out=fetch PC, il_out=1 in the same cycle.
  - The word is not pushed, so fetch-to-IR latency drops by one cycle.
- When undefined: the word is always pushed first; il_out no earlier than the next cycle.

Test Plan:
- Reset:
  - Stimulus: hold rst 2 cycles with fetch_en_in=1.
  - Response: req=0, addr=0000, il_out=0, ins_out=0000, pc_out=0000, empty_out=1.
- Streaming:
  - Stimulus: memory acks the cycle after req with data=addr+16'h1000; ins_req_in held 1.
  - Response: il_out pulses, ins_out 1000,1001,1002 with pc_out 0000,0001,0002; no gaps after the first.
- Backpressure:
  - Stimulus: ins_req_in=0 with FIFO_DEPTH=2.
  - Response: after two acks, full_out=1 and req=0 with addr=0002. Raising ins_req_in gives one il_out (ins_out=1000) and req reasserts next cycle.
- Redirect in flight:
  - Stimulus: ack delayed 3 cycles; pc_load_in=1 with target 0040 in the second WAIT cycle.
  - Response: state DROP; returned word discarded; empty_out=1; next request addr=0040; first delivered ins_out=1040 with pc_out=0040.
- Redirect with consume:
  - Stimulus: pc_load_in=1 and ins_req_in=1 in the same cycle with FIFO non-empty.
  - Response: il_out=0 and FIFO flushed.
- Wrap-around:
  - Stimulus: PC_RESET=FFFF.
  - Response: addresses issued FFFF then 0000.
  - With IFETCH_BYPASS_EN, the first ack gives il_out in the ack cycle.
